// File: rtl/prog_tone_divider_if.sv
// Configuration port of the programmable tone divider.
// Valid/ready contract: a configuration (div_val, duty_val) transfers on a
// rising clk edge where cfg_valid && cfg_ready are both high. The master
// holds the data stable while cfg_valid is high. The slave drives cfg_ready
// from a register, so it never depends combinationally on cfg_valid.
interface prog_tone_divider_if #(
   parameter int CNT_W = 16
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [CNT_W-1:0] div_val;
   logic [CNT_W-1:0] duty_val;

   modport master (
      output cfg_valid,
      output div_val,
      output duty_val,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  div_val,
      input  duty_val,
      output cfg_ready
   );
endinterface

// File: rtl/prog_tone_divider.sv
// Runtime-programmable clock/tone divider.
// Produces a registered square-wave enable (oclk) with period N and high
// time H, plus a one-cycle tick on the first cycle of each period. A new
// (N, H) pair is captured into a shadow register through the config port
// and only becomes active at a period boundary, so oclk never glitches.
// An active N below 2 parks the block in an idle mode with outputs low.
module prog_tone_divider #(
   parameter int CNT_W    = 16,
   parameter int RST_DIV  = 4,
   parameter int RST_DUTY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   prog_tone_divider_if.slave    cfg,
   output logic                  oclk,
   output logic                  tick,
   output logic                  running
);

   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO  = CNT_W'(2);
   localparam logic [CNT_W-1:0] ZERO = '0;

   // High time is forced into [1, N-1]; for N < 2 the result is unused.
   function automatic logic [CNT_W-1:0] clamp_duty(
      input logic [CNT_W-1:0] n,
      input logic [CNT_W-1:0] h
   );
      if (h == ZERO) begin
         return ONE;
      end else if (h >= n) begin
         return n - ONE;
      end else begin
         return h;
      end
   endfunction

   localparam logic [CNT_W-1:0] RST_DIV_V  = CNT_W'(RST_DIV);
   localparam logic [CNT_W-1:0] RST_DUTY_V = clamp_duty(CNT_W'(RST_DIV), CNT_W'(RST_DUTY));

   // Active settings, counter, shadow config and registered outputs
   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] duty_q, duty_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] sh_div_q, sh_div_d;
   logic [CNT_W-1:0] sh_duty_q, sh_duty_d;
   logic             pend_q, pend_d;
   logic             ready_q, ready_d;
   logic             oclk_q, oclk_d;
   logic             tick_q, tick_d;

   // Helper values for the boundary decision
   logic             accept;
   logic             run_mode;
   logic             at_boundary;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] new_div;
   logic [CNT_W-1:0] new_duty;

   assign accept      = cfg.cfg_valid && ready_q;
   assign run_mode    = (div_q >= TWO);
   assign at_boundary = (cnt_q == (div_q - ONE));
   assign cnt_inc     = cnt_q + ONE;

   // Settings that take effect at the next boundary: shadow if pending, else current
   always_comb begin
      new_div  = div_q;
      new_duty = duty_q;
      if (pend_q) begin
         new_div  = sh_div_q;
         new_duty = sh_duty_q;
      end
   end

   // Next-state logic for counter, outputs, active settings and handshake
   always_comb begin
      div_d     = div_q;
      duty_d    = duty_q;
      cnt_d     = cnt_q;
      sh_div_d  = sh_div_q;
      sh_duty_d = sh_duty_q;
      pend_d    = pend_q;
      oclk_d    = oclk_q;
      tick_d    = 1'b0;

      if (!run_mode) begin
         // Idle: outputs parked low; a pending config loads regardless of en
         cnt_d  = ZERO;
         oclk_d = 1'b0;
         if (pend_q) begin
            div_d  = sh_div_q;
            duty_d = sh_duty_q;
            pend_d = 1'b0;
            // Preload to the last count so the first enabled edge starts a period
            if (sh_div_q >= TWO) begin
               cnt_d = sh_div_q - ONE;
            end
         end
      end else if (en) begin
         if (at_boundary) begin
            // The boundary consumes only a config that was already pending;
            // one accepted on this same edge waits for the next boundary.
            div_d  = new_div;
            duty_d = new_duty;
            pend_d = 1'b0;
            cnt_d  = ZERO;
            if (new_div >= TWO) begin
               tick_d = 1'b1;
               oclk_d = (ZERO < new_duty);
            end else begin
               tick_d = 1'b0;
               oclk_d = 1'b0;
            end
         end else begin
            cnt_d  = cnt_inc;
            oclk_d = (cnt_inc < duty_q);
         end
      end

      // ready_q is the inverse of pend_q, so an accept never overwrites a pending config
      if (accept) begin
         sh_div_d  = cfg.div_val;
         sh_duty_d = clamp_duty(cfg.div_val, cfg.duty_val);
         pend_d    = 1'b1;
      end

      ready_d = !pend_d;
   end

   // State register with synchronous active-low reset back to the defaults
   always_ff @(posedge clk) begin
      if (!rst) begin
         div_q     <= RST_DIV_V;
         duty_q    <= RST_DUTY_V;
         cnt_q     <= RST_DIV_V - ONE;
         sh_div_q  <= ZERO;
         sh_duty_q <= ZERO;
         pend_q    <= 1'b0;
         ready_q   <= 1'b1;
         oclk_q    <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         div_q     <= div_d;
         duty_q    <= duty_d;
         cnt_q     <= cnt_d;
         sh_div_q  <= sh_div_d;
         sh_duty_q <= sh_duty_d;
         pend_q    <= pend_d;
         ready_q   <= ready_d;
         oclk_q    <= oclk_d;
         tick_q    <= tick_d;
      end
   end

   assign cfg.cfg_ready = ready_q;
   assign oclk          = oclk_q;
   assign tick          = tick_q;
   assign running       = run_mode;

endmodule

// File: doc/prog_tone_divider.md
Name: prog_tone_divider

Overview:
Runtime-programmable clock/tone divider, the generalised successor of the fixed divide-by-4 stage. It produces a square-wave enable `oclk` with programmable period and high time, plus a one-cycle `tick` at each period start. New settings arrive over a valid/ready port and take effect only at a period boundary, so the output never glitches. It feeds the oscillator/note generators of the synthesizer and defaults after reset to divide-by-4 at 50% duty.

Parameters:
CNT_W, 16, width of counter, div_val and duty_val
RST_DIV, 4, active period N (clk cycles) loaded at reset
RST_DUTY, 2, active high time H (clk cycles) loaded at reset

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-low reset, sampled on rising clk
en  input  1  count enable; low freezes counter and outputs
cfg_valid  input  1  new configuration offered
cfg_ready  output  1  block can accept a configuration
div_val  input  CNT_W  requested period N in clk cycles
duty_val  input  CNT_W  requested high time H in clk cycles
oclk  output  1  divided square output, registered
tick  output  1  one-cycle pulse on first cycle of each period, registered
running  output  1  active N >= 2

Behaviour:
- Reset (rst low at a clk edge; dominates all other inputs):
  - active N = RST_DIV, active H = clamp(RST_DUTY).
  - cnt = RST_DIV-1; pending = 0; shadow cleared.
  - oclk = 0; tick = 0; cfg_ready = 1; running = (RST_DIV >= 2).
- Clamp, applied on accept and at reset:
  - H = 0 gives H = 1.
  - H >= N gives H = N-1.
  - If N < 2, H is don't-care.
- Handshake:
  - Accept when cfg_valid && cfg_ready: clamped div/duty go to the shadow and pending is set.
  - cfg_ready = !pending, registered, so it is low from the cycle after accept.
  - Only one configuration may be pending; cfg_valid while cfg_ready = 0 is ignored, with no overwrite.
- Running mode (active N >= 2), en high:
  - cnt_next = (cnt == N-1) ? 0 : cnt+1.
  - oclk <= (cnt_next < H).
  - tick <= (cnt_next == 0).
  - Period is exactly N cycles with H high and N-H low; the first enabled edge after reset yields tick = 1 and oclk = 1.
- Boundary:
  - The edge where cnt == N-1 with en = 1.
  - If pending, active N/H take the shadow values and pending clears.
  - The new period starts immediately: cnt = 0, tick = 1, oclk = (0 < H_new).
  - cfg_ready returns high the next cycle.
- Idle mode (active N < 2):
  - cnt = 0, oclk = 0, tick = 0, running = 0.
  - A pending config is applied on the next edge regardless of en.
  - On that edge cnt = N_new-1 and outputs stay 0; the first enabled edge afterwards starts a period.
- en low:
  - cnt, oclk and N/H hold.
  - tick forced 0.
  - No boundary occurs, so pending waits; accept is still allowed.
- Simultaneous accept and boundary on the same edge: the boundary uses the old state (no pending). The new config waits for the next boundary.
- Arithmetic:
  - Unsigned, CNT_W bits.
  - cnt never exceeds N-1; no wrap-around beyond it.
  - div_val = 2^CNT_W-1 is legal.
- Reset mid-period or with a pending config returns to defaults; pending is discarded.

Test Plan:
- Default run: rst low 3 cycles, release, en = 1 -> tick on edges 1, 5, 9, ...; oclk pattern 1,1,0,0 repeating; cfg_ready = 1, running = 1.
- Reconfigure mid-period: at cnt = 1 offer div = 5, duty = 2 -> accepted that edge; cfg_ready low until boundary. Old 4-cycle period completes, then tick every 5 with oclk 1,1,0,0,0; cfg_ready high the cycle after the boundary.
- Clamp: duty = 0, div = 6 -> oclk high 1 of 6. Then duty = 9, div = 5 -> oclk high 4 of 5. A second cfg_valid while pending is ignored, with the value unchanged.
- Idle and restart: div = 1 -> after boundary, oclk = 0, tick = 0, running = 0. Offer div = 3, duty = 1 -> applied the next edge; then tick every 3 cycles, oclk 1,0,0.
- Enable gating: en low for 3 cycles at cnt = 2 (div = 4) -> outputs frozen, no tick, period stretched to 7 cycles; counting resumes from cnt = 3.
- Reset mid-operation: pending config present, rst low 1 cycle -> oclk = 0, tick = 0, cfg_ready = 1; the pending config is lost and the default divide-by-4 behaviour resumes.
